uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: 2nd generation of the uart_regs-side receive path.

---
 rtl/uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, break detection and a first-word-fall-through RX FIFO.
// A frame is pushed on the clk of the last stop-bit decision. When the FIFO is full, the frame is dropped and overrun_o is set.
module uart_rx_fifo #(
  parameter int OSR         = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int RTS_THRESH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          tick_i,
  input  logic [1:0]                    wlen_i,
  input  logic [1:0]                    pmode_i,
  input  logic                          stop2_i,
  input  logic                          rxd_i,
  input  logic                          pop_i,
  output logic [7:0]                    rd_data_o,
  output logic                          rd_ferr_o,
  output logic                          rd_perr_o,
  output logic                          rd_brk_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  input  logic                          clr_ovr_i,
  output logic                          busy_o,
  output logic                          rts_n_o
);
  localparam int TW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [TW-1:0] T_S0  = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OSR / 2);
  localparam logic [TW-1:0] T_DEC = TW'(OSR / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OSR - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;
  typedef struct packed {
    logic       brk;
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } entry_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_prev_q, rxd_prev_d;
  state_t                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             data_q, data_d;
  logic [1:0]             samp_q, samp_d;
  logic [1:0]             wlen_q, wlen_d, pmode_q, pmode_d;
  logic                   stop2_q, stop2_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
  entry_t                 mem_q [FIFO_DEPTH];
  entry_t                 mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovr_q, ovr_d;

  logic   rxd_s, start_edge, bit_tick, end_tick, bit_val, last_data, last_stop, frame_brk;
  logic   exp_par, push_req, do_push, do_pop, full;
  entry_t entry, head;

  assign rxd_s      = sync_q[SYNC_STAGES-1];
  assign start_edge = enable_i && rxd_prev_q && !rxd_s;
  assign bit_tick   = tick_i && (tcnt_q == T_DEC);
  assign end_tick   = tick_i && (tcnt_q == T_END);
  // Two stored samples plus the live one form the 2-of-3 vote.
  assign bit_val    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
  assign last_data  = (bitcnt_q == ({1'b0, wlen_q} + 3'd4));
  assign last_stop  = (bitcnt_q[0] == stop2_q);
  assign frame_brk  = zero_q && !bit_val;

  always_comb begin
    case (pmode_q)
      2'b01:   exp_par = ^data_q;
      2'b10:   exp_par = ~^data_q;
      default: exp_par = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
      state_q    <= IDLE;
      tcnt_q     <= '0;
      bitcnt_q   <= '0;
      data_q     <= '0;
      samp_q     <= '0;
      wlen_q     <= '0;
      pmode_q    <= '0;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovr_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q     <= sync_d;
      rxd_prev_q <= rxd_prev_d;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bitcnt_q   <= bitcnt_d;
      data_q     <= data_d;
      samp_q     <= samp_d;
      wlen_q     <= wlen_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovr_q      <= ovr_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_edge) state_d = START;
        START:   if (bit_tick && bit_val) state_d = IDLE;
                 else if (end_tick) state_d = DATA;
        DATA:    if (end_tick && last_data) state_d = (pmode_q != 2'b00) ? PARITY : STOP;
        PARITY:  if (end_tick) state_d = STOP;
        // Leave mid-stop so the next start edge can resync early.
        STOP:    if (bit_tick && last_stop) state_d = frame_brk ? BRKWAIT : IDLE;
        BRKWAIT: if (rxd_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o   = (state_q != IDLE);
    push_req = enable_i && (state_q == STOP) && bit_tick && last_stop;
    entry.brk  = frame_brk;
    entry.perr = frame_brk ? 1'b0 : perr_q;
    entry.ferr = frame_brk | ferr_q | !bit_val;
    entry.data = frame_brk ? 8'h00 : data_q;
  end

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rxd_i};
    rxd_prev_d = rxd_s;
    tcnt_d     = tcnt_q;
    bitcnt_d   = bitcnt_q;
    data_d     = data_q;
    samp_d     = samp_q;
    wlen_d     = wlen_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    if (state_q == IDLE) begin
      tcnt_d   = '0;
      bitcnt_d = '0;
      if (start_edge) begin
        wlen_d  = wlen_i;
        pmode_d = pmode_i;
        stop2_d = stop2_i;
        data_d  = '0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        zero_d  = 1'b1;
      end
    end else if (tick_i) begin
      tcnt_d = (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;
      if (tcnt_q == T_S0) samp_d[0] = rxd_s;
      if (tcnt_q == T_S1) samp_d[1] = rxd_s;
      if (bit_tick) begin
        if (bit_val) zero_d = 1'b0;
        case (state_q)
          DATA:    data_d[bitcnt_q] = bit_val;
          PARITY:  perr_d = (bit_val != exp_par);
          STOP:    if (!bit_val) ferr_d = 1'b1;
          default: ;
        endcase
      end
      if (end_tick) begin
        case (state_q)
          DATA:    bitcnt_d = last_data ? 3'd0 : bitcnt_q + 3'd1;
          STOP:    bitcnt_d = bitcnt_q + 3'd1;
          default: ;
        endcase
      end
    end
  end

  // A pop on a full FIFO frees the slot the same-clk push needs.
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_req && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovr_d    = clr_ovr_i ? 1'b0 : ovr_q;
    if (push_req && full && !do_pop) ovr_d = 1'b1;
    if (do_push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    empty_o   = (level_q == '0);
    full_o    = full;
    level_o   = level_q;
    overrun_o = ovr_q;
    rd_data_o = empty_o ? 8'h00 : head.data;
    rd_ferr_o = !empty_o && head.ferr;
    rd_perr_o = !empty_o && head.perr;
    rd_brk_o  = !empty_o && head.brk;
    rts_n_o   = !enable_i || (level_q >= LW'(RTS_THRESH));
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames are driven tick-accurately, expected FIFO entries go to a
// scoreboard queue as each frame is sent and are compared against the FIFO head as entries are popped.
module tb_uart_rx_fifo;
  localparam int OSR   = 16;
  localparam int DEPTH = 4;
  localparam int THR   = 3;

  logic       clk = 1'b0, rst_n = 1'b0, enable_i = 1'b0, tick_i = 1'b0;
  logic [1:0] wlen_i = 2'b11, pmode_i = 2'b00;
  logic       stop2_i = 1'b0, rxd_i = 1'b1, pop_i = 1'b0, clr_ovr_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rd_ferr_o, rd_perr_o, rd_brk_o, empty_o, full_o, overrun_o, busy_o, rts_n_o;
  logic [2:0] level_o;

  int n_cmp = 0;
  int n_err = 0;
  int tdiv  = 0;
  logic [10:0] exp_q[$];   // {brk, perr, ferr, data}
  logic [10:0] e;

  uart_rx_fifo #(.OSR(OSR), .FIFO_DEPTH(DEPTH), .RTS_THRESH(THR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .tick_i(tick_i), .wlen_i(wlen_i),
    .pmode_i(pmode_i), .stop2_i(stop2_i), .rxd_i(rxd_i), .pop_i(pop_i),
    .rd_data_o(rd_data_o), .rd_ferr_o(rd_ferr_o), .rd_perr_o(rd_perr_o), .rd_brk_o(rd_brk_o),
    .empty_o(empty_o), .full_o(full_o), .level_o(level_o), .overrun_o(overrun_o),
    .clr_ovr_i(clr_ovr_i), .busy_o(busy_o), .rts_n_o(rts_n_o)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 tick_i = (tdiv == 3);
      tdiv = (tdiv + 1) % 4;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick_i !== 1'b1);
    end
    #2;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Sends start, nb data bits, optional parity (flipped if pflip), ns stop bits, then one idle bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] pm,
                            input logic pflip, input logic [1:0] stops, input int ns,
                            input int glitch, input bit expect_push);
    logic [15:0] bits;
    logic [7:0]  dm;
    logic        par, ferr;
    int          n;
    dm = d & 8'((1 << nb) - 1);
    bits = '0;
    n = 1;
    for (int i = 0; i < nb; i++) begin bits[n] = dm[i]; n++; end
    if (pm != 2'b00) begin
      par = (pm == 2'b01) ? ^dm : (pm == 2'b10) ? ~^dm : 1'b1;
      bits[n] = par ^ pflip;
      n++;
    end
    for (int i = 0; i < ns; i++) begin bits[n] = stops[i]; n++; end
    ferr = (ns == 2) ? !(stops[0] & stops[1]) : !stops[0];
    if (expect_push) exp_q.push_back({1'b0, (pm != 2'b00) && pflip, ferr, dm});
    wlen_i = 2'(nb - 5);
    pmode_i = pm;
    stop2_i = (ns == 2);
    for (int i = 0; i < n; i++) begin
      rxd_i = bits[i];
      if (i == glitch) begin
        wait_ticks(8); rxd_i = ~bits[i]; wait_ticks(1); rxd_i = bits[i]; wait_ticks(7);
      end else begin
        wait_ticks(OSR);
      end
    end
    rxd_i = 1'b1;
    wait_ticks(OSR);
  endtask

  task automatic pop_one();
    @(posedge clk); #1 pop_i = 1'b1;
    @(posedge clk); #1 pop_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable_i = 1'b0;
    wait_clks(3);
    @(negedge clk);
    n_cmp++; if ({empty_o, full_o, level_o, overrun_o, busy_o} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_flags: got e=%b f=%b l=%0d o=%b b=%b, want 1 0 0 0 0", empty_o, full_o, level_o, overrun_o, busy_o); end
    n_cmp++; if ({rd_data_o, rd_ferr_o, rd_perr_o, rd_brk_o} !== 11'h0) begin
      n_err++; $display("FAIL reset_rd: got %h/%b%b%b, want 0", rd_data_o, rd_ferr_o, rd_perr_o, rd_brk_o); end
    n_cmp++; if (rts_n_o !== 1'b1) begin n_err++; $display("FAIL reset_rts_disabled: got %b want 1", rts_n_o); end
    rst_n = 1'b1; enable_i = 1'b1;
    wait_clks(4);
    @(negedge clk);
    n_cmp++; if (rts_n_o !== 1'b0) begin n_err++; $display("FAIL reset_rts_enabled: got %b want 0", rts_n_o); end
  endtask

  task automatic test_8n1();
    send_frame(8'hA5, 8, 2'b00, 1'b0, 2'b01, 1, -1, 1'b1);
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd1) begin n_err++; $display("FAIL 8n1_level: got %0d want 1", level_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_cmp++; if ({rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o} !== e) begin
        n_err++; $display("FAIL 8n1_head: got %h want %h", {rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o}, e); end
      pop_one();
    end
    @(negedge clk);
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL 8n1_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_parity();
    send_frame(8'h35, 7, 2'b01, 1'b1, 2'b11, 2, -1, 1'b1);
    send_frame(8'h35, 7, 2'b01, 1'b1, 2'b01, 2, -1, 1'b1);
    send_frame(8'h4C, 6, 2'b11, 1'b0, 2'b01, 1, -1, 1'b1);
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd3) begin n_err++; $display("FAIL parity_level: got %0d want 3", level_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_cmp++; if ({rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o} !== e) begin
        n_err++; $display("FAIL parity_head: got %h want %h", {rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o}, e); end
      pop_one();
    end
  endtask

  task automatic test_false_start();
    rxd_i = 1'b0;
    wait_ticks(2);
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL false_start_busy: got %b want 1", busy_o); end
    wait_ticks(2);
    rxd_i = 1'b1;
    wait_ticks(2 * OSR);
    @(negedge clk);
    n_cmp++; if ({busy_o, level_o} !== {1'b0, 3'd0}) begin
      n_err++; $display("FAIL false_start_idle: got busy=%b level=%0d want 0 0", busy_o, level_o); end
    send_frame(8'h00, 8, 2'b00, 1'b0, 2'b01, 1, 4, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_cmp++; if ({rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o} !== e) begin
        n_err++; $display("FAIL glitch_head: got %h want %h", {rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o}, e); end
      pop_one();
    end
  endtask

  task automatic test_break();
    wlen_i = 2'b11; pmode_i = 2'b00; stop2_i = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h00});
    rxd_i = 1'b0;
    wait_ticks(20 * OSR);
    @(negedge clk);
    n_cmp++; if ({busy_o, level_o} !== {1'b1, 3'd1}) begin
      n_err++; $display("FAIL break_hold: got busy=%b level=%0d want 1 1", busy_o, level_o); end
    rxd_i = 1'b1;
    wait_ticks(OSR);
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL break_release: got busy=%b want 0", busy_o); end
    send_frame(8'h5A, 8, 2'b00, 1'b0, 2'b01, 1, -1, 1'b1);
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd2) begin n_err++; $display("FAIL break_level: got %0d want 2", level_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_cmp++; if ({rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o} !== e) begin
        n_err++; $display("FAIL break_head: got %h want %h", {rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o}, e); end
      pop_one();
    end
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      send_frame(bytes[i], 8, 2'b00, 1'b0, 2'b01, 1, -1, i < DEPTH);
      @(negedge clk);
      n_cmp++; if (rts_n_o !== (i + 1 >= THR)) begin
        n_err++; $display("FAIL ovr_rts%0d: got %b want %b", i, rts_n_o, (i + 1 >= THR)); end
      n_cmp++; if ({full_o, overrun_o} !== {i + 1 >= DEPTH, i + 1 > DEPTH}) begin
        n_err++; $display("FAIL ovr_flags%0d: got full=%b ovr=%b", i, full_o, overrun_o); end
    end
    @(posedge clk); #1 clr_ovr_i = 1'b1;
    @(posedge clk); #1 clr_ovr_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({overrun_o, level_o} !== {1'b0, 3'd4}) begin
      n_err++; $display("FAIL ovr_clear: got ovr=%b level=%0d want 0 4", overrun_o, level_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_cmp++; if ({rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o} !== e) begin
        n_err++; $display("FAIL ovr_head: got %h want %h", {rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o}, e); end
      pop_one();
    end
    @(negedge clk);
    n_cmp++; if ({empty_o, rts_n_o} !== 2'b10) begin
      n_err++; $display("FAIL ovr_drained: got empty=%b rts_n=%b want 1 0", empty_o, rts_n_o); end
  endtask

  task automatic test_abort();
    wlen_i = 2'b11; pmode_i = 2'b00; stop2_i = 1'b0;
    rxd_i = 1'b0; wait_ticks(OSR);
    rxd_i = 1'b1; wait_ticks(3 * OSR);
    rst_n = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_ticks(2 * OSR);
    @(negedge clk);
    n_cmp++; if ({busy_o, level_o} !== {1'b0, 3'd0}) begin
      n_err++; $display("FAIL abort_reset: got busy=%b level=%0d want 0 0", busy_o, level_o); end
    rxd_i = 1'b0; wait_ticks(OSR);
    rxd_i = 1'b1; wait_ticks(2 * OSR);
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b want 1", busy_o); end
    enable_i = 1'b0;
    wait_clks(2);
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_disable: got busy=%b want 0", busy_o); end
    wait_ticks(10 * OSR);
    enable_i = 1'b1;
    wait_ticks(OSR);
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd0) begin n_err++; $display("FAIL abort_level: got %0d want 0", level_o); end
    send_frame(8'h1F, 5, 2'b00, 1'b0, 2'b01, 1, -1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_cmp++; if ({rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o} !== e) begin
        n_err++; $display("FAIL abort_recover_head: got %h want %h", {rd_brk_o, rd_perr_o, rd_ferr_o, rd_data_o}, e); end
      pop_one();
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_break();
    test_overrun();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
